button_pio_irq: RTL and testbench

//  Avalon-MM slave input PIO for push buttons, parametrised in width, with per-bit sync + debounce,

---
 rtl/button_pio_pkg.sv | 24 ++
 rtl/button_pio_irq_debounce.sv | 62 ++++++
 rtl/button_pio_irq.sv | 98 +++++++++
 tb/tb_button_pio_irq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/button_pio_pkg.sv
// Shared register map and edge-mode encodings for the push-button PIO.
package button_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    function automatic logic edge_hit(input int edge_type, input logic prev, input logic cur);
        logic w_hit;
        w_hit = 1'b0;
        case (edge_type)
            EDGE_RISE: w_hit = !prev && cur;
            EDGE_FALL: w_hit = prev && !cur;
            default:   w_hit = prev != cur;
        endcase
        return w_hit;
    endfunction

endpackage

// File: rtl/button_pio_irq_debounce.sv
// One-bit 2-FF synchronizer followed by a stable-count debouncer.
module button_debounce #(
    parameter int DEBOUNCE_CYC = 500000,
    parameter bit IDLE_LEVEL   = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_stable
);

    logic r_sync_p0;
    logic r_sync_p1;
    logic r_stable;

    // Stage p0/p1: metastability filter on the asynchronous pin.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync_p0 <= IDLE_LEVEL;
            r_sync_p1 <= IDLE_LEVEL;
        end else begin
            r_sync_p0 <= i_raw;
            r_sync_p1 <= r_sync_p0;
        end
    end

    generate
        if (DEBOUNCE_CYC == 0) begin : g_bypass
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_stable <= IDLE_LEVEL;
                end else begin
                    r_stable <= r_sync_p1;
                end
            end
        end else begin : g_count
            localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

            logic [CNT_W-1:0] r_cnt;

            // Stage p2: accept the synced level only after an unbroken run of
            // DEBOUNCE_CYC differing samples; >= keeps the counter from wrapping.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_cnt    <= '0;
                    r_stable <= IDLE_LEVEL;
                end else if (r_sync_p1 == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt >= CNT_LAST) begin
                    r_cnt    <= '0;
                    r_stable <= r_sync_p1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    endgenerate

    assign o_stable = r_stable;

endmodule

// File: rtl/button_pio_irq.sv
// Avalon-MM push-button input PIO: debounced data, sticky edge capture,
// interrupt mask and level IRQ.
module button_pio_irq
    import button_pio_pkg::*;
#(
    parameter int WIDTH        = 2,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int EDGE_TYPE    = EDGE_FALL,
    parameter bit IDLE_LEVEL   = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] r_stable_q;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic [WIDTH-1:0] w_wbits;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr;
    logic [31:0]      w_rdmux;
    logic             w_unused;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            button_debounce #(
                .DEBOUNCE_CYC (DEBOUNCE_CYC),
                .IDLE_LEVEL   (IDLE_LEVEL)
            ) u_deb (
                .i_clk    (clk),
                .i_rst_n  (reset_n),
                .i_raw    (in_port[gi]),
                .o_stable (w_stable[gi])
            );
        end
    endgenerate

    // Upper write-data bits have no storage behind them.
    assign w_unused = ^writedata;
    assign w_wbits  = writedata[WIDTH-1:0];
    assign w_wr     = chipselect && !write_n;
    assign w_clr    = (w_wr && address == ADDR_EDGE) ? w_wbits : '0;

    always_comb begin
        w_edge = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_edge[i] = edge_hit(EDGE_TYPE, r_stable_q[i], w_stable[i]);
        end
    end

    // Stage p3: edge history, capture and mask registers. A new edge is OR-ed
    // in after the clear, so an edge colliding with a W1C survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable_q <= {WIDTH{IDLE_LEVEL}};
            r_edgecap  <= '0;
            r_irqmask  <= '0;
        end else begin
            r_stable_q <= w_stable;
            r_edgecap  <= (r_edgecap & ~w_clr) | w_edge;
            if (w_wr && address == ADDR_MASK) begin
                r_irqmask <= w_wbits;
            end
        end
    end

    always_comb begin
        w_rdmux = '0;
        case (address)
            ADDR_DATA: w_rdmux = 32'(w_stable);
            ADDR_MASK: w_rdmux = 32'(r_irqmask);
            ADDR_EDGE: w_rdmux = 32'(r_edgecap);
            default:   w_rdmux = '0;
        endcase
    end

    // Stage p4: registered read port, no read strobe needed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= w_rdmux;
        end
    end

    assign irq = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_button_pio_irq.sv
// Bench for button_pio_irq: instance 0 uses DEBOUNCE_CYC=8 falling-edge,
// instance 1 uses DEBOUNCE_CYC=0 any-edge; both are shadowed by a cycle model.
module tb_button_pio_irq;

    logic        clk;
    logic        rn   [2];
    logic [1:0]  addr [2];
    logic        cs   [2];
    logic        wn   [2];
    logic [31:0] wd   [2];
    logic [1:0]  inp  [2];
    logic [31:0] rd   [2];
    logic        irq  [2];

    int n_cmp = 0;
    int n_bad = 0;

    button_pio_irq #(.WIDTH(2), .DEBOUNCE_CYC(8), .EDGE_TYPE(1), .IDLE_LEVEL(1'b1)) dut_a (
        .clk(clk), .reset_n(rn[0]), .address(addr[0]), .chipselect(cs[0]), .write_n(wn[0]),
        .writedata(wd[0]), .in_port(inp[0]), .readdata(rd[0]), .irq(irq[0]));

    button_pio_irq #(.WIDTH(2), .DEBOUNCE_CYC(0), .EDGE_TYPE(2), .IDLE_LEVEL(1'b1)) dut_b (
        .clk(clk), .reset_n(rn[1]), .address(addr[1]), .chipselect(cs[1]), .write_n(wn[1]),
        .writedata(wd[1]), .in_port(inp[1]), .readdata(rd[1]), .irq(irq[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: sync is a 2-sample delay line; debounced level adopts the synced
    // value once that value has persisted for DC consecutive samples.
    int          DCM [2] = '{8, 0};
    int          ETM [2] = '{1, 2};
    logic [1:0]  m_d1 [2], m_d2 [2], m_last [2], m_stab [2], m_pend [2];
    logic [1:0]  m_mask [2], m_ec [2];
    logic [31:0] m_rd [2];
    int          m_run [2][2];

    task automatic model_step(input int k);
        logic [1:0] clr;
        clr = 2'b00;
        if (!rn[k]) begin
            m_d1[k] = 2'b11; m_d2[k] = 2'b11; m_last[k] = 2'b11; m_stab[k] = 2'b11;
            m_pend[k] = 2'b00; m_mask[k] = 2'b00; m_ec[k] = 2'b00; m_rd[k] = 32'd0;
            m_run[k][0] = 0; m_run[k][1] = 0;
        end else begin
            case (addr[k])
                2'd0: m_rd[k] = {30'd0, m_stab[k]};
                2'd2: m_rd[k] = {30'd0, m_mask[k]};
                2'd3: m_rd[k] = {30'd0, m_ec[k]};
                default: m_rd[k] = 32'd0;
            endcase
            if (cs[k] && !wn[k] && addr[k] == 2'd3) clr = wd[k][1:0];
            m_ec[k] = (m_ec[k] & ~clr) | m_pend[k];
            if (cs[k] && !wn[k] && addr[k] == 2'd2) m_mask[k] = wd[k][1:0];
            m_pend[k] = 2'b00;
            for (int b = 0; b < 2; b++) begin
                if (m_d2[k][b] == m_last[k][b]) begin
                    if (m_run[k][b] < 1000) m_run[k][b] = m_run[k][b] + 1;
                end else begin
                    m_run[k][b] = 1;
                end
                m_last[k][b] = m_d2[k][b];
                if (m_d2[k][b] != m_stab[k][b] && m_run[k][b] >= DCM[k]) begin
                    m_stab[k][b] = m_d2[k][b];
                    m_pend[k][b] = (ETM[k] == 2) || (ETM[k] == 1 && !m_d2[k][b])
                                   || (ETM[k] == 0 && m_d2[k][b]);
                end
            end
            m_d2[k] = m_d1[k];
            m_d1[k] = inp[k];
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step(0);
        model_step(1);
    end

    initial forever begin
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("model_rd%0d", k), rd[k], m_rd[k]);
            check($sformatf("model_irq%0d", k), {31'd0, irq[k]}, {31'd0, |(m_ec[k] & m_mask[k])});
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_wr(input int k, input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        addr[k] = a; wd[k] = d; cs[k] = 1'b1; wn[k] = 1'b0;
        @(negedge clk);
        cs[k] = 1'b0; wn[k] = 1'b1;
    endtask

    task automatic rd_chk(input int k, input logic [1:0] a, input logic [31:0] exp, input string nm);
        @(negedge clk);
        addr[k] = a;
        @(negedge clk);
        check(nm, rd[k], exp);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rn[k] = 1'b0; cs[k] = 1'b0; wn[k] = 1'b1; wd[k] = 32'd0;
        end
        addr[0] = 2'd3; addr[1] = 2'd0;
        inp[0] = 2'b00; inp[1] = 2'b11;

        // Reset with keys held, then release: edge appears only after 2+8+1.
        wait_cyc(4);
        check("t1_reset_rd", rd[0], 32'd0);
        check("t1_reset_irq", {31'd0, irq[0]}, 32'd0);
        @(negedge clk); rn[0] = 1'b1;
        wait_cyc(11);
        check("t1_ec_early", rd[0], 32'd0);
        wait_cyc(1);
        check("t1_ec_set", rd[0], 32'd3);
        bus_wr(0, 2'd3, 32'd3);
        rd_chk(0, 2'd3, 32'd0, "t1_ec_cleared");

        // Bounce shorter than the debounce window is ignored.
        @(negedge clk); inp[0] = 2'b11;
        wait_cyc(20);
        @(negedge clk); inp[0] = 2'b10;
        wait_cyc(5);
        inp[0] = 2'b11;
        wait_cyc(15);
        rd_chk(0, 2'd0, 32'h3, "t2_glitch_data");
        rd_chk(0, 2'd3, 32'h0, "t2_glitch_ec");
        @(negedge clk); inp[0] = 2'b10;
        wait_cyc(15);
        rd_chk(0, 2'd0, 32'h2, "t2_press_data");
        rd_chk(0, 2'd3, 32'h1, "t2_press_ec");
        bus_wr(0, 2'd3, 32'h1);

        // Interrupt masking.
        bus_wr(0, 2'd2, 32'h1);
        @(negedge clk); inp[0] = 2'b11;
        wait_cyc(15);
        check("t3_release_no_irq", {31'd0, irq[0]}, 32'd0);
        @(negedge clk); inp[0] = 2'b10;
        wait_cyc(13);
        check("t3_irq_on", {31'd0, irq[0]}, 32'd1);
        bus_wr(0, 2'd3, 32'h1);
        check("t3_irq_cleared", {31'd0, irq[0]}, 32'd0);
        @(negedge clk); inp[0] = 2'b00;
        wait_cyc(13);
        rd_chk(0, 2'd3, 32'h2, "t3_ec_bit1");
        check("t3_irq_masked", {31'd0, irq[0]}, 32'd0);
        bus_wr(0, 2'd2, 32'h3);
        check("t3_irq_unmask", {31'd0, irq[0]}, 32'd1);
        bus_wr(0, 2'd0, 32'h0);
        bus_wr(0, 2'd1, 32'h0);
        rd_chk(0, 2'd2, 32'h3, "t3_mask_kept");

        // Edge and W1C on bit0 in the same clock: edge wins.
        bus_wr(0, 2'd3, 32'h3);
        @(negedge clk); inp[0] = 2'b11;
        wait_cyc(15);
        @(negedge clk); inp[0] = 2'b10;
        wait_cyc(9);
        bus_wr(0, 2'd3, 32'h1);
        rd_chk(0, 2'd3, 32'h1, "t4_collision");
        bus_wr(0, 2'd3, 32'h1);
        rd_chk(0, 2'd3, 32'h0, "t4_plain_clear");

        // Reset in mid-bounce discards the partial count.
        @(negedge clk); inp[0] = 2'b11;
        wait_cyc(15);
        @(negedge clk); inp[0] = 2'b10;
        wait_cyc(5);
        rn[0] = 1'b0;
        wait_cyc(2);
        inp[0] = 2'b11;
        rn[0] = 1'b1;
        wait_cyc(15);
        rd_chk(0, 2'd3, 32'h0, "t4_rst_ec");
        rd_chk(0, 2'd2, 32'h0, "t4_rst_mask");

        // Any-edge, no debounce.
        @(negedge clk); rn[1] = 1'b1;
        wait_cyc(5);
        @(negedge clk); inp[1] = 2'b01;
        wait_cyc(3);
        check("t5_data_before", rd[1], 32'h3);
        wait_cyc(1);
        check("t5_data_after", rd[1], 32'h1);
        rd_chk(1, 2'd3, 32'h2, "t5_press_ec");
        bus_wr(1, 2'd3, 32'hFFFF_FFFE);
        rd_chk(1, 2'd3, 32'h0, "t5_clear_ec");
        @(negedge clk); inp[1] = 2'b11;
        wait_cyc(6);
        rd_chk(1, 2'd3, 32'h2, "t5_release_ec");
        rd_chk(1, 2'd0, 32'h3, "t5_release_data");
        rd_chk(1, 2'd1, 32'h0, "t5_reserved");
        bus_wr(1, 2'd2, 32'hFFFF_FFFC);
        rd_chk(1, 2'd2, 32'h0, "t5_mask_hi_ignored");
        check("t5_irq_off", {31'd0, irq[1]}, 32'd0);
        bus_wr(1, 2'd2, 32'hFFFF_FFFE);
        check("t5_irq_on", {31'd0, irq[1]}, 32'd1);
        rd_chk(1, 2'd2, 32'h2, "t5_mask_bit1");

        wait_cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
